product_accumulator8: RTL and testbench
=======================================

Name: product_accumulator8

Overview:
- Downstream consumer of the 8x8 Wallace-tree multiplier: accepts 16-bit unsigned products over a valid/ready handshake.
- Sums a fixed-length batch of LEN products into an ACC_W-bit accumulator, then presents the sum as a registered result with its own valid/ready handshake.
- Forms the accumulate half of an 8-bit dot-product / MAC datapath.

Parameters:
- LEN, 8, products per batch (>=1).
- ACC_W, 19, accumulator/result width; 16+clog2(LEN) guarantees no overflow.
- CNT_W, 4, batch counter width; must satisfy 2^CNT_W > LEN.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous batch abort.
- product_i  input  16  unsigned product from the multiplier.
- valid_i  input  1  product_i is valid.
- ready_o  output  1  block accepts product_i this cycle.
- result_o  output  ACC_W  batch sum.
- result_valid_o  output  1  result_o holds a completed batch.
- result_ready_i  input  1  downstream takes the result.
- overflow_o  output  1  carry out of ACC_W occurred during this batch.
- count_o  output  CNT_W  products accepted so far in the current batch.

Behaviour:
- Reset (rst_ni=0, asynchronous): state=ACCUM, acc=0, count_o=0, result_o=0, result_valid_o=0, overflow_o=0. ready_o=1 the first cycle after reset deasserts.
- ready_o = (state==ACCUM) && !clear_i. It is combinational from state and clear_i only, never from valid_i.
- Accept event = valid_i && ready_o.

State ACCUM, on an accept:
- acc <= acc + zero-extended product_i, modulo 2^ACC_W.
- If the addition carries out of bit ACC_W-1, overflow_o <= 1. The flag is sticky for the batch.
- count_o <= count_o+1.
- If count_o==LEN-1 at accept (the LEN-th product): result_o <= new sum, result_valid_o <= 1, count_o <= 0, state <= DONE.
- Latency: result_valid_o rises the cycle after the LEN-th accept.

State DONE:
- ready_o=0; no products are accepted.
- result_o, overflow_o and result_valid_o hold stable while result_ready_i=0 (backpressure).
- On result_valid_o && result_ready_i: result_valid_o <= 0, acc <= 0, overflow_o <= 0, state <= ACCUM. ready_o=1 the following cycle, so the minimum batch period is LEN+1 cycles.
- result_o keeps its last value after the handshake; it is not cleared.

clear_i (synchronous, highest priority below reset):
- acc <= 0, count_o <= 0, overflow_o <= 0, result_valid_o <= 0, state <= ACCUM.
- Any valid_i in that cycle is not accepted, since ready_o=0.
- In DONE, clear_i discards the pending result even if result_ready_i=1 in the same cycle.

Other rules:
- valid_i while ready_o=0: no state change. The upstream must hold product_i/valid_i.
- LEN=1: every accept goes straight to DONE with result_o=product_i.
- Reset asserted mid-batch or in DONE: everything returns immediately to reset values and the partial sum is lost.
- No X propagation: result_o is defined at all times after reset.

Test Plan:
- Basic batch (defaults): 8 back-to-back accepts of 0xFE01 (255*255), result_ready_i=1 → result_valid_o high for one cycle, 9 cycles after the first accept. result_o=0x7F008 (520200), overflow_o=0, ready_o low for exactly one cycle.
- Backpressure: products 1..8, result_ready_i=0 for 5 cycles after result_valid_o rises:
  - result_o=36 held stable with ready_o=0 throughout.
  - Raise result_ready_i → ready_o=1 the next cycle.
  - A following batch of 8×0x0001 gives result_o=8.
- Gapped input: valid_i toggling 1,0,1,0,… with product_i=0x0100 → count_o increments only on accepts, result_o=0x800 after 8 accepts.
- Overflow (LEN=4, ACC_W=17): 4×0xFE01 → result_o=129028 (260100 mod 131072), overflow_o=1 from the third accept onward. overflow_o=0 after the result handshake.
- clear_i mid-batch: 3 accepts of 0x1234, then clear_i=1 with valid_i=1 → count_o=0, product not taken. The next 8 accepts of 0x0002 give result_o=16. clear_i asserted in DONE with result_ready_i=1 → result_valid_o drops and state=ACCUM.
- Async reset: assert rst_ni=0 between clock edges with count_o=5 → count_o, result_valid_o and overflow_o go to 0 immediately without waiting for a clock edge. ready_o=1 after release.

Source files
------------

// File: rtl/product_accumulator8.sv
// Batch accumulator for 16-bit unsigned products: sums LEN accepted products
// and presents the total as a registered result behind a valid/ready handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_ACCUM | taking products, count_o tracks position in the batch
// S_DONE  | result_o/overflow_o held until downstream takes the result
module product_accumulator8 #(
  parameter int LEN   = 8,
  parameter int ACC_W = 19,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [15:0]      product_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [ACC_W-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             overflow_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t             r_state, w_state_nx;
  logic [ACC_W-1:0]   r_acc, w_acc_nx;
  logic [ACC_W-1:0]   r_result, w_result_nx;
  logic [CNT_W-1:0]   r_count, w_count_nx;
  logic               r_result_valid, w_result_valid_nx;
  logic               r_overflow, w_overflow_nx;
  logic [ACC_W:0]     w_sum;
  logic               w_accept;

  assign ready_o        = (r_state == S_ACCUM) && !clear_i;
  assign w_accept       = valid_i && ready_o;
  // One extra bit captures the carry out of the accumulator.
  assign w_sum          = {1'b0, r_acc} + (ACC_W + 1)'(product_i);
  assign result_o       = r_result;
  assign result_valid_o = r_result_valid;
  assign overflow_o     = r_overflow;
  assign count_o        = r_count;

  always_comb begin
    w_state_nx        = r_state;
    w_acc_nx          = r_acc;
    w_result_nx       = r_result;
    w_count_nx        = r_count;
    w_result_valid_nx = r_result_valid;
    w_overflow_nx     = r_overflow;
    if (clear_i) begin
      w_acc_nx          = '0;
      w_count_nx        = '0;
      w_overflow_nx     = 1'b0;
      w_result_valid_nx = 1'b0;
      w_state_nx        = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            w_acc_nx = w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) w_overflow_nx = 1'b1;
            if (r_count == LAST) begin
              w_result_nx       = w_sum[ACC_W-1:0];
              w_result_valid_nx = 1'b1;
              w_count_nx        = '0;
              w_state_nx        = S_DONE;
            end else begin
              w_count_nx = r_count + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          // result_o is deliberately left untouched after the handshake.
          if (r_result_valid && result_ready_i) begin
            w_result_valid_nx = 1'b0;
            w_acc_nx          = '0;
            w_overflow_nx     = 1'b0;
            w_state_nx        = S_ACCUM;
          end
        end
        default: w_state_nx = S_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_ACCUM;
      r_acc          <= '0;
      r_result       <= '0;
      r_count        <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_acc          <= w_acc_nx;
      r_result       <= w_result_nx;
      r_count        <= w_count_nx;
      r_result_valid <= w_result_valid_nx;
      r_overflow     <= w_overflow_nx;
    end
  end

endmodule

// File: tb/tb_product_accumulator8.sv
// Self-checking bench for product_accumulator8: per-cycle vector table plus
// a scoreboard of expected batch results popped when result_valid_o rises.
module tb_product_accumulator8;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        clear, valid, rready, ready, rvalid, ovf;
  logic [15:0] product;
  logic [18:0] result;
  logic [3:0]  count;

  logic        clear2, valid2, rready2, ready2, rvalid2, ovf2;
  logic [15:0] product2;
  logic [16:0] result2;
  logic [2:0]  count2;

  product_accumulator8 dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .product_i(product),
    .valid_i(valid), .ready_o(ready), .result_o(result),
    .result_valid_o(rvalid), .result_ready_i(rready),
    .overflow_o(ovf), .count_o(count)
  );

  product_accumulator8 #(.LEN(4), .ACC_W(17), .CNT_W(3)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear2), .product_i(product2),
    .valid_i(valid2), .ready_o(ready2), .result_o(result2),
    .result_valid_o(rvalid2), .result_ready_i(rready2),
    .overflow_o(ovf2), .count_o(count2)
  );

  typedef struct {
    logic [15:0] p;
    logic        v;
    logic        clr;
    logic        rr;
    logic        exp_ready;
    logic [3:0]  exp_count;
    logic        exp_rvalid;
  } vec_t;

  typedef struct {
    logic [18:0] res;
    logic        ovf;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        prev_rvalid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] p);
    exp_t e;
    m_acc = m_acc + p;
    if (m_acc >= 524288) begin
      m_acc = m_acc - 524288;
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == 8) begin
      e.res = m_acc[18:0];
      e.ovf = m_ovf;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic accept(input logic [15:0] p);
    int n;
    n = 0;
    product = p;
    valid   = 1'b1;
    #1;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, expected 1", n);
    end else begin
      step();
      model_accept(p);
    end
    valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    product = t.p;
    valid   = t.v;
    clear   = t.clr;
    rready  = t.rr;
    #1;
    check($sformatf("vec%0d_ready", idx), ready, t.exp_ready);
    step();
    if (t.v && t.exp_ready) model_accept(t.p);
    check($sformatf("vec%0d_count", idx), count, t.exp_count);
    check($sformatf("vec%0d_rvalid", idx), rvalid, t.exp_rvalid);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rvalid && !prev_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: result_o=%0d with no batch expected", result);
      end else begin
        e = sb.pop_front();
        check("sb_result", result, e.res);
        check("sb_overflow", ovf, e.ovf);
      end
    end
    prev_rvalid = rvalid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int unsigned s2;
    logic        e_ovf2;

    rst_n = 1'b0;
    clear = 0; valid = 0; rready = 0; product = '0;
    clear2 = 0; valid2 = 0; rready2 = 0; product2 = '0;
    #23 rst_n = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_overflow", ovf, 0);
    check("rst_result", result, 0);
    check("rst_ready", ready, 1);
    check("rst_ready4", ready2, 1);
    step();

    // back-to-back batch of 255*255, then gapped batch of 0x0100
    for (int i = 0; i < 8; i++) begin
      v = '{16'hFE01, 1'b1, 1'b0, 1'b1, 1'b1, 4'((i + 1) % 8), (i == 7)};
      tbl.push_back(v);
    end
    tbl.push_back('{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        v = '{16'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 4'((i / 2 + 1) % 8), (i == 14)};
      else
        v = '{16'h0100, 1'b0, 1'b0, 1'b1, (i != 15), 4'(((i + 1) / 2) % 8), 1'b0};
      tbl.push_back(v);
    end
    tbl.push_back('{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], i);
      if (i == 9) begin
        check("basic_result", result, 19'h7F008);
        check("basic_overflow", ovf, 0);
      end
    end
    check("gapped_result", result, 19'h00800);

    // backpressure
    rready = 1'b0;
    for (int k = 1; k <= 8; k++) accept(16'(k));
    check("bp_rvalid_rise", rvalid, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_ready_hold", ready, 0);
      check("bp_result_hold", result, 36);
      check("bp_rvalid_hold", rvalid, 1);
      step();
    end
    rready = 1'b1;
    step();
    check("bp_rvalid_drop", rvalid, 0);
    check("bp_ready_back", ready, 1);
    for (int k = 0; k < 8; k++) accept(16'h0001);
    step();
    check("bp_next_result", result, 8);

    // overflow on the LEN=4, ACC_W=17 instance
    s2 = 0;
    for (int k = 0; k < 4; k++) begin
      valid2   = 1'b1;
      product2 = 16'hFE01;
      #1;
      check("ovf4_ready", ready2, 1);
      step();
      s2     = s2 + 32'hFE01;
      e_ovf2 = (s2 >= 131072);
      check($sformatf("ovf4_flag%0d", k), ovf2, e_ovf2);
      check($sformatf("ovf4_count%0d", k), count2, 3'((k + 1) % 4));
      valid2 = 1'b0;
    end
    check("ovf4_rvalid", rvalid2, 1);
    check("ovf4_result_model", result2, 17'(s2 % 131072));
    check("ovf4_result", result2, 129028);
    rready2 = 1'b1;
    step();
    check("ovf4_flag_cleared", ovf2, 0);
    check("ovf4_rvalid_drop", rvalid2, 0);
    rready2 = 1'b0;

    // clear mid-batch, then clear while a result is pending
    rready = 1'b1;
    for (int k = 0; k < 3; k++) accept(16'h1234);
    check("clr_count_pre", count, 3);
    clear = 1'b1; valid = 1'b1; product = 16'h1234;
    #1;
    check("clr_ready", ready, 0);
    step();
    check("clr_count", count, 0);
    clear = 1'b0; valid = 1'b0;
    model_clear();
    rready = 1'b0;
    for (int k = 0; k < 8; k++) accept(16'h0002);
    check("clr_batch_rvalid", rvalid, 1);
    check("clr_batch_result", result, 16);
    clear = 1'b1; rready = 1'b1;
    step();
    check("clr_done_rvalid", rvalid, 0);
    clear = 1'b0; rready = 1'b0;
    #1;
    check("clr_done_ready", ready, 1);
    step();

    // asynchronous reset mid-batch, with the LEN=4 instance carrying overflow
    for (int k = 0; k < 3; k++) begin
      valid2 = 1'b1; product2 = 16'hFE01;
      step();
    end
    valid2 = 1'b0;
    check("ar_ovf4_pre", ovf2, 1);
    rready = 1'b1;
    for (int k = 0; k < 5; k++) accept(16'h0003);
    check("ar_count_pre", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", count, 0);
    check("ar_rvalid", rvalid, 0);
    check("ar_overflow", ovf, 0);
    check("ar_ovf4", ovf2, 0);
    check("ar_count4", count2, 0);
    #2 rst_n = 1'b1;
    model_clear();
    #1;
    check("ar_ready", ready, 1);
    step();
    check("ar_ready_after_edge", ready, 1);
    check("ar_count_after_edge", count, 0);

    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d batches never produced, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
